// File: rtl/reg_file_bist.sv
// reg_file_bist: built-in self-test initiator for a 32 x 32-bit register file.
// Writes Dp(i) = PATTERN | i (pass 0) or its complement (pass 1) to x1..x31,
// then reads every register back on both read ports and checks the data.
// Reports pass/fail, the first failing address/port/data and a saturating
// mismatch count.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 start request, sampled in IDLE only
//   raddr_rs1/raddr_rs2   read addresses driven to the register file
//   rdata_rs1/rdata_rs2   combinational read data from the register file
//   waddr_rd/wdata_rd/we  write port driven to the register file
//   busy, done            test in progress / one-cycle end pulse
//   pass                  1 = no mismatch in the last run
//   fail_addr/port/data   first mismatch (port 0 = rs1, 1 = rs2)
//   err_count             mismatch count, saturates at 255
//
// Configuration macro: REG_BIST_STOP_ON_FAIL_EN -- when defined, the first
// mismatch ends the test on the next cycle.
module reg_file_bist #(
   parameter logic [31:0] PATTERN = 32'hA5A5_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [4:0]  raddr_rs1,
   output logic [4:0]  raddr_rs2,
   output logic [4:0]  waddr_rd,
   output logic [31:0] wdata_rd,
   output logic        we,
   input  logic [31:0] rdata_rs1,
   input  logic [31:0] rdata_rs2,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [4:0]  fail_addr,
   output logic        fail_port,
   output logic [31:0] fail_data,
   output logic [7:0]  err_count
);

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

   state_t          state, state_n;
   logic [AW-1:0]   idx, idx_n;
   logic            p, p_n;
   logic            first_fail;
   logic [AW-1:0]   addr2;
   logic            mis1, mis2;
   logic [1:0]      inc;
   logic [CW:0]     err_sum;

   // Pattern for register a in pass pp; x0 always reads as zero.
   function automatic logic [DW-1:0] exp_data(input logic pp, input logic [AW-1:0] a);
      logic [DW-1:0] d;
      d = PATTERN | DW'(a);
      if (a == '0)
         return '0;
      return pp ? ~d : d;
   endfunction

   // Read checks for the current READ cycle; addresses mirror the registered outputs.
   always_comb begin
      addr2   = AW'(5'd31 - idx);
      mis1    = (state == READ) && (rdata_rs1 != exp_data(p, idx));
      mis2    = (state == READ) && (rdata_rs2 != exp_data(p, addr2));
      inc     = {1'b0, mis1} + {1'b0, mis2};
      err_sum = {1'b0, err_count} + (CW+1)'(inc);
   end

   // Next-state sequencing.
   always_comb begin
      state_n = state;
      idx_n   = idx;
      p_n     = p;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = WRITE;
               idx_n   = AW'(1);
               p_n     = 1'b0;
            end
         end
         WRITE: begin
            if (idx == AW'(31)) begin
               state_n = READ;
               idx_n   = '0;
            end else begin
               idx_n = idx + AW'(1);
            end
         end
         READ: begin
            if (idx == AW'(31)) begin
               if (!p) begin
                  state_n = WRITE;
                  idx_n   = AW'(1);
                  p_n     = 1'b1;
               end else begin
                  state_n = DONE;
               end
            end else begin
               idx_n = idx + AW'(1);
            end
`ifdef REG_BIST_STOP_ON_FAIL_EN
            if (mis1 || mis2)
               state_n = DONE;
`endif
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State, registered port outputs (derived from next state) and result tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         p          <= 1'b0;
         we         <= 1'b0;
         waddr_rd   <= '0;
         wdata_rd   <= '0;
         raddr_rs1  <= '0;
         raddr_rs2  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail_addr  <= '0;
         fail_port  <= 1'b0;
         fail_data  <= '0;
         err_count  <= '0;
         first_fail <= 1'b0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         p         <= p_n;
         we        <= (state_n == WRITE);
         waddr_rd  <= (state_n == WRITE) ? idx_n : '0;
         wdata_rd  <= (state_n == WRITE) ? exp_data(p_n, idx_n) : '0;
         raddr_rs1 <= (state_n == READ) ? idx_n : '0;
         raddr_rs2 <= (state_n == READ) ? AW'(5'd31 - idx_n) : '0;
         busy      <= (state_n == WRITE) || (state_n == READ);
         done      <= (state_n == DONE);

         if (state == IDLE && start) begin
            err_count  <= '0;
            fail_addr  <= '0;
            fail_port  <= 1'b0;
            fail_data  <= '0;
            first_fail <= 1'b0;
            pass       <= 1'b1;
         end else if (mis1 || mis2) begin
            pass      <= 1'b0;
            err_count <= err_sum[CW] ? {CW{1'b1}} : err_sum[CW-1:0];
            // rs1 wins when both ports fail first in the same cycle.
            if (!first_fail) begin
               first_fail <= 1'b1;
               fail_addr  <= mis1 ? idx : addr2;
               fail_port  <= !mis1;
               fail_data  <= mis1 ? rdata_rs1 : rdata_rs2;
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_file_bist.sv
// Directed self-checking bench for reg_file_bist with a behavioural register
// file that can inject an x7 bit-3 stuck-at-1 fault or make x0 read 1.
module tb_reg_file_bist;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [4:0]  raddr_rs1, raddr_rs2, waddr_rd;
   logic [31:0] wdata_rd, rdata_rs1, rdata_rs2;
   logic        we, busy, done, pass, fail_port;
   logic [4:0]  fail_addr;
   logic [31:0] fail_data;
   logic [7:0]  err_count;

   logic [31:0] rf [32];
   logic        fault_x7;
   logic        fault_x0;

   int tests;
   int fails;

   int done_cyc, we_cyc, busy_cyc, busy_first, busy_last;

   reg_file_bist dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .raddr_rs1(raddr_rs1), .raddr_rs2(raddr_rs2),
      .waddr_rd(waddr_rd), .wdata_rd(wdata_rd), .we(we),
      .rdata_rs1(rdata_rs1), .rdata_rs2(rdata_rs2),
      .busy(busy), .done(done), .pass(pass),
      .fail_addr(fail_addr), .fail_port(fail_port), .fail_data(fail_data),
      .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model: synchronous write, combinational reads, x0 hardwired.
   always @(posedge clk)
      if (we && waddr_rd != 5'd0)
         rf[waddr_rd] <= wdata_rd;

   always_comb begin
      rdata_rs1 = (raddr_rs1 == 5'd0) ? {31'd0, fault_x0} : rf[raddr_rs1];
      if (fault_x7 && raddr_rs1 == 5'd7) rdata_rs1[3] = 1'b1;
   end

   always_comb begin
      rdata_rs2 = (raddr_rs2 == 5'd0) ? {31'd0, fault_x0} : rf[raddr_rs2];
      if (fault_x7 && raddr_rs2 == 5'd7) rdata_rs2[3] = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start so the sampling edge is edge 0; returns in the done cycle.
   task automatic run_bist(input bit pulse20);
      start = 1'b1;
      tick();
      start = 1'b0;
      done_cyc = -1; we_cyc = 0; busy_cyc = 0; busy_first = -1; busy_last = -1;
      for (int c = 1; c <= 200; c++) begin
         start = pulse20 && (c == 20);
         if (we) we_cyc++;
         if (busy) begin
            busy_cyc++;
            if (busy_first < 0) busy_first = c;
            busy_last = c;
         end
         if (done) begin
            done_cyc = c;
            break;
         end
         tick();
      end
      start = 1'b0;
   endtask

   initial begin
      tests = 0; fails = 0;
      fault_x7 = 1'b0; fault_x0 = 1'b0;
      start = 1'b0;
      rst_n = 1'b0;
      repeat (2) tick();

      // Reset state
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_err", 32'(err_count), 32'd0);
      check("rst_we", 32'(we), 32'd0);
      check("rst_fail_data", fail_data, 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();
      check("idle_busy", 32'(busy), 32'd0);

      // Fault-free run
      run_bist(1'b0);
      check("ok_done_cyc", 32'(done_cyc), 32'd127);
      check("ok_busy_cycles", 32'(busy_cyc), 32'd126);
      check("ok_busy_first", 32'(busy_first), 32'd1);
      check("ok_busy_last", 32'(busy_last), 32'd126);
      check("ok_we_cycles", 32'(we_cyc), 32'd62);
      check("ok_pass", 32'(pass), 32'd1);
      check("ok_err", 32'(err_count), 32'd0);
      check("ok_rf_x5", rf[5], 32'h5A5A_FFFA);
      check("ok_rf_x31", rf[31], 32'h5A5A_FFE0);
      tick();
      check("ok_done_pulse_end", 32'(done), 32'd0);
      tick();

      // Start pulsed while busy is ignored
      run_bist(1'b1);
      check("busy_start_done_cyc", 32'(done_cyc), 32'd127);
      check("busy_start_pass", 32'(pass), 32'd1);
      repeat (2) tick();

      // x7 bit 3 stuck-at-1
      fault_x7 = 1'b1;
      run_bist(1'b0);
`ifdef REG_BIST_STOP_ON_FAIL_EN
      check("x7_done_cyc", 32'(done_cyc), 32'd40);
      check("x7_err", 32'(err_count), 32'd1);
`else
      check("x7_done_cyc", 32'(done_cyc), 32'd127);
      check("x7_err", 32'(err_count), 32'd2);
`endif
      check("x7_fail_addr", 32'(fail_addr), 32'd7);
      check("x7_fail_port", 32'(fail_port), 32'd0);
      check("x7_fail_data", fail_data, 32'hA5A5_000F);
      check("x7_pass", 32'(pass), 32'd0);
      fault_x7 = 1'b0;
      repeat (2) tick();

      // x0 reads 1
      fault_x0 = 1'b1;
      run_bist(1'b0);
`ifdef REG_BIST_STOP_ON_FAIL_EN
      check("x0_done_cyc", 32'(done_cyc), 32'd33);
      check("x0_err", 32'(err_count), 32'd1);
`else
      check("x0_done_cyc", 32'(done_cyc), 32'd127);
      check("x0_err", 32'(err_count), 32'd4);
`endif
      check("x0_fail_addr", 32'(fail_addr), 32'd0);
      check("x0_fail_port", 32'(fail_port), 32'd0);
      check("x0_fail_data", fail_data, 32'h1);
      check("x0_pass", 32'(pass), 32'd0);
      fault_x0 = 1'b0;
      repeat (2) tick();

      // Reset asserted during cycle 50 (x7 fault present so err_count is nonzero)
      fault_x7 = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (49) tick();
`ifndef REG_BIST_STOP_ON_FAIL_EN
      check("rst50_busy_before", 32'(busy), 32'd1);
      check("rst50_err_before", 32'(err_count), 32'd1);
`endif
      rst_n = 1'b0;
      #1;
      check("rst50_busy", 32'(busy), 32'd0);
      check("rst50_we", 32'(we), 32'd0);
      check("rst50_err", 32'(err_count), 32'd0);
      tick();
      rst_n = 1'b1;
      fault_x7 = 1'b0;
      busy_cyc = 0;
      for (int c = 0; c < 10; c++) begin
         if (busy || done || we) busy_cyc++;
         tick();
      end
      check("rst50_stays_idle", 32'(busy_cyc), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
